fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_pc_next.sv | 47 ++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Definitions shared by the fetch unit RTL and its testbench:
//   - fetch_state_e : sequencer states (2-bit encoding)
//   - OP_WIDTH      : width of the opcode field, which sits in the top bits
//                     of the instruction word
//   - HALT_OP       : opcode that stops fetching until the next reset
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam int              OP_WIDTH = 4;
    localparam logic [3:0]      HALT_OP  = 4'hF;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// -----------------------------------------------------------------------------
// fetch_unit_pc_next
// Purely combinational next-program-counter calculator (the pc_next block).
// Ports:
//   pc_i      in  PC_WIDTH     current program counter
//   instr_i   in  INSTR_WIDTH  instruction being executed
//   jump_i    in  1            take absolute target instr_i[PC_WIDTH-1:0]
//   branch_i  in  1            take PC + 1 + sign-extended instr_i[7:0]
//   next_pc_o out PC_WIDTH     resulting PC (modulo 2^PC_WIDTH)
// JUMP has priority over BRANCH.
// -----------------------------------------------------------------------------
module fetch_unit_pc_next
    import fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic [PC_WIDTH-1:0]    pc_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic                   jump_i,
    input  logic                   branch_i,
    output logic [PC_WIDTH-1:0]    next_pc_o
);

    logic [PC_WIDTH-1:0] seqPc;
    logic [PC_WIDTH-1:0] branchOffset;
    logic                unusedInstrBits;

    // Replicate the offset sign bit well past PC_WIDTH and keep the low bits,
    // which gives a correct sign extension (or truncation) for any PC_WIDTH.
    assign branchOffset = PC_WIDTH'({{PC_WIDTH{instr_i[7]}}, instr_i[7:0]});
    assign seqPc        = pc_i + PC_WIDTH'(1);

    // The opcode bits never influence the target address.
    assign unusedInstrBits = ^instr_i;

    // Wrap-around comes for free from the PC_WIDTH-bit adders.
    always_comb begin
        next_pc_o = seqPc;
        if (jump_i) begin
            next_pc_o = instr_i[PC_WIDTH-1:0];
        end else if (branch_i) begin
            next_pc_o = seqPc + branchOffset;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch sequencer: fetches a word from instruction memory at PC,
// holds it in the instruction register while the control unit executes it,
// then advances PC (sequential, jump or branch) or halts on opcode 4'hF.
// Ports:
//   CLK         in   1            clock, rising edge
//   RST         in   1            synchronous active-high reset
//   IMEM_ADDR   out  PC_WIDTH     memory address (= PC)
//   IMEM_REQ    out  1            fetch request (decoded from state register)
//   IMEM_ACK    in   1            IMEM_RDATA valid this cycle
//   IMEM_RDATA  in   INSTR_WIDTH  fetched word
//   INSTR       out  INSTR_WIDTH  instruction register
//   OP          out  4            opcode field of INSTR
//   VALID       out  1            INSTR is executing this cycle
//   JUMP        in   1            take absolute target
//   BRANCH      in   1            take relative target
//   STALL       in   1            hold the executing instruction
//   PC          out  PC_WIDTH     program counter
//   HALTED      out  1            halt opcode retired
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   CLK,
    input  logic                   RST,
    output logic [PC_WIDTH-1:0]    IMEM_ADDR,
    output logic                   IMEM_REQ,
    input  logic                   IMEM_ACK,
    input  logic [INSTR_WIDTH-1:0] IMEM_RDATA,
    output logic [INSTR_WIDTH-1:0] INSTR,
    output logic [3:0]             OP,
    output logic                   VALID,
    input  logic                   JUMP,
    input  logic                   BRANCH,
    input  logic                   STALL,
    output logic [PC_WIDTH-1:0]    PC,
    output logic                   HALTED
);

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    nextPc;
    logic [3:0]             opField;

    assign opField = instr_q[INSTR_WIDTH-1 -: OP_WIDTH];

    fetch_unit_pc_next #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_pc_next (
        .pc_i      (pc_q),
        .instr_i   (instr_q),
        .jump_i    (JUMP),
        .branch_i  (BRANCH),
        .next_pc_o (nextPc)
    );

    // Reset wins over everything, including an ACK arriving in the same
    // cycle, so a withdrawn fetch can never load the instruction register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // ACK only matters while fetching; a stalled EXEC ignores JUMP/BRANCH
    // because nothing is committed until STALL drops.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (IMEM_ACK) begin
                    instr_d = IMEM_RDATA;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!STALL) begin
                    if (opField == HALT_OP) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = nextPc;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs come straight from the state register so they are
    // glitch-free and independent of the memory/control inputs.
    assign IMEM_REQ  = (state_q == ST_FETCH);
    assign VALID     = (state_q == ST_EXEC);
    assign HALTED    = (state_q == ST_HALT);
    assign IMEM_ADDR = pc_q;
    assign PC        = pc_q;
    assign INSTR     = instr_q;
    assign OP        = opField;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Drives the fetch unit from a behavioural memory with directed and random
// stimulus; an instruction-level model predicts PC/INSTR/status every cycle.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int PCW = 8;
    localparam int IW  = 16;

    logic           CLK;
    logic           RST;
    logic [PCW-1:0] IMEM_ADDR;
    logic           IMEM_REQ;
    logic           IMEM_ACK;
    logic [IW-1:0]  IMEM_RDATA;
    logic [IW-1:0]  INSTR;
    logic [3:0]     OP;
    logic           VALID;
    logic           JUMP;
    logic           BRANCH;
    logic           STALL;
    logic [PCW-1:0] PC;
    logic           HALTED;

    logic [IW-1:0]  mem [256];

    int checks = 0;
    int errors = 0;

    // Model of what the unit must be showing: PC, instruction register,
    // and whether it is fetching, executing, halted, or none (post-reset).
    logic [PCW-1:0] expPc;
    logic [IW-1:0]  expInstr;
    logic           expReq;
    logic           expValid;
    logic           expHalted;

    fetch_unit #(
        .PC_WIDTH    (PCW),
        .INSTR_WIDTH (IW),
        .RESET_PC    (8'h00)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IMEM_ADDR  (IMEM_ADDR),
        .IMEM_REQ   (IMEM_REQ),
        .IMEM_ACK   (IMEM_ACK),
        .IMEM_RDATA (IMEM_RDATA),
        .INSTR      (INSTR),
        .OP         (OP),
        .VALID      (VALID),
        .JUMP       (JUMP),
        .BRANCH     (BRANCH),
        .STALL      (STALL),
        .PC         (PC),
        .HALTED     (HALTED)
    );

    assign IMEM_RDATA = mem[IMEM_ADDR];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PCW-1:0] modelTarget(input logic [PCW-1:0] pc, input logic [IW-1:0] instr,
                                                   input logic j, input logic b);
        int t;
        int off;
        off = int'(instr[7:0]);
        if (off > 127) off = off - 256;
        if (j)      t = int'(instr[7:0]);
        else if (b) t = int'(pc) + 1 + off;
        else        t = int'(pc) + 1;
        t = t & 255;
        return t[PCW-1:0];
    endfunction

    task automatic checkOutput();
        checkVal("pc",     32'(PC),        32'(expPc));
        checkVal("addr",   32'(IMEM_ADDR), 32'(expPc));
        checkVal("instr",  32'(INSTR),     32'(expInstr));
        checkVal("op",     32'(OP),        32'(expInstr >> 12));
        checkVal("req",    32'(IMEM_REQ),  32'(expReq));
        checkVal("valid",  32'(VALID),     32'(expValid));
        checkVal("halted", 32'(HALTED),    32'(expHalted));
    endtask

    // Drive one cycle of inputs, advance the model by the same edge, then
    // compare one time unit after the edge.
    task automatic applyStimulus(input logic r, input logic a, input logic j, input logic b, input logic s);
        RST = r; IMEM_ACK = a; JUMP = j; BRANCH = b; STALL = s;
        if (r) begin
            expPc = 8'h00; expInstr = '0;
            expReq = 0; expValid = 0; expHalted = 0;
        end else if (expHalted) begin
            // frozen
        end else if (expReq) begin
            if (a) begin
                expInstr = mem[expPc];
                expReq = 0; expValid = 1;
            end
        end else if (expValid) begin
            if (!s) begin
                expValid = 0;
                if (expInstr[15:12] == HALT_OP) expHalted = 1;
                else begin
                    expPc  = modelTarget(expPc, expInstr, j, b);
                    expReq = 1;
                end
            end
        end else begin
            expReq = 1;
        end
        @(posedge CLK);
        #1;
        checkOutput();
    endtask

    task automatic fillMem(input logic [IW-1:0] w);
        for (int i = 0; i < 256; i++) mem[i] = w;
    endtask

    int reqCount;
    int validCount;

    initial begin
        RST = 1; IMEM_ACK = 0; JUMP = 0; BRANCH = 0; STALL = 0;
        expPc = '0; expInstr = '0; expReq = 0; expValid = 0; expHalted = 0;

        // Straight-line code, ACK always high: two cycles per instruction.
        fillMem(16'h1000);
        applyStimulus(1, 1, 0, 0, 0);
        checkVal("lit_rst_pc",  32'(PC), 32'h0);
        checkVal("lit_rst_req", 32'(IMEM_REQ), 32'h0);
        checkVal("lit_rst_op",  32'(OP), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 1, 0, 0, 0);
            checkVal("lit_seq_pc",    32'(PC), 32'((k - 1) / 2));
            checkVal("lit_seq_valid", 32'(VALID), 32'(k % 2 == 0));
            if (k % 2 == 0) checkVal("lit_seq_op", 32'(OP), 32'h1);
        end

        // Jump from PC 5, then jump+branch together from PC 5.
        for (int pass = 0; pass < 2; pass++) begin
            fillMem(16'h1000);
            mem[5] = 16'h2042;
            applyStimulus(1, 1, 0, 0, 0);
            for (int k = 1; k <= 12; k++) applyStimulus(0, 1, 0, 0, 0);
            checkVal("lit_pc5", 32'(PC), 32'h5);
            applyStimulus(0, 1, 1, pass == 1, 0);
            checkVal("lit_jump_addr", 32'(IMEM_ADDR), 32'h42);
        end

        // Backward branch from 0x10, then wrap from 0xFF.
        fillMem(16'h1000);
        mem[8'h00] = 16'h2010;
        mem[8'h10] = 16'h30FE;
        mem[8'h0F] = 16'h20FF;
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkVal("lit_pc10", 32'(PC), 32'h10);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkVal("lit_branch_back", 32'(PC), 32'h0F);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkVal("lit_pcff", 32'(PC), 32'hFF);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkVal("lit_wrap", 32'(PC), 32'h00);

        // Slow memory (ACK ignored while idle, then 3 cycles late) and stall.
        fillMem(16'h1000);
        applyStimulus(1, 0, 0, 0, 0);
        reqCount = 0;
        applyStimulus(0, 1, 0, 0, 0); reqCount += int'(IMEM_REQ);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0); reqCount += int'(IMEM_REQ);
            checkVal("lit_addr_hold", 32'(IMEM_ADDR), 32'h0);
        end
        applyStimulus(0, 1, 0, 0, 0); reqCount += int'(IMEM_REQ);
        checkVal("lit_req_cycles", 32'(reqCount), 32'd4);
        validCount = int'(VALID);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 1, 1, 1, 1); validCount += int'(VALID);
            checkVal("lit_stall_pc", 32'(PC), 32'h0);
        end
        applyStimulus(0, 1, 0, 0, 0); validCount += int'(VALID);
        checkVal("lit_valid_cycles", 32'(validCount), 32'd3);
        checkVal("lit_release_pc", 32'(PC), 32'h1);

        // Halt opcode: frozen until reset.
        fillMem(16'h1000);
        mem[0] = 16'hF000;
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkVal("lit_halted", 32'(HALTED), 32'h1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
            checkVal("lit_halt_req", 32'(IMEM_REQ), 32'h0);
            checkVal("lit_halt_pc",  32'(PC), 32'h0);
        end
        applyStimulus(1, 0, 0, 0, 0);
        checkVal("lit_unhalt", 32'(HALTED), 32'h0);

        // Reset coinciding with ACK in FETCH must not load the word.
        mem[0] = 16'h1234;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkVal("lit_rst_fetch_instr", 32'(INSTR), 32'h0);
        checkVal("lit_rst_fetch_req",   32'(IMEM_REQ), 32'h0);

        // Random programs and control inputs.
        for (int n = 0; n < 4000; n++) begin
            logic r;
            r = ($urandom_range(0, 99) == 0) || (expHalted && $urandom_range(0, 7) == 0);
            if (r) begin
                for (int i = 0; i < 256; i++) begin
                    mem[i] = 16'($urandom);
                    if (mem[i][15:12] == 4'hF && $urandom_range(0, 3) != 0)
                        mem[i][15:12] = 4'($urandom_range(0, 14));
                end
            end
            applyStimulus(r, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
